cache_port_arbiter: RTL and testbench
=====================================

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning the cache byte-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the max consecutive FSM-owned cycles while the bus waits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have ports fsm_ren, fsm_wen, input, 1 each, the FSM requester's read and write request.
REQ-006 SHALL have port fsm_addr, input, ADDR_WIDTH, the FSM address.
REQ-007 SHALL have ports fsm_wdata, input, 32, and fsm_strobe, input, 4, the FSM write data and byte enables.
REQ-008 SHALL have ports fsm_rdata, output, 32; fsm_error, output, 1; fsm_request_stall, output, 1, the FSM response.
REQ-009 SHALL have ports bus_ren, bus_wen, bus_addr, bus_wdata and bus_strobe, inputs, with the same widths and meaning for the bus requester.
REQ-010 SHALL have ports bus_rdata, bus_error and bus_request_stall, outputs, as the bus response.
REQ-011 SHALL have ports cache_ren, cache_wen, cache_addr, cache_wdata and cache_strobe, outputs, driving the single-port cache.
REQ-012 SHALL have ports cache_rdata, input, 32; cache_error, input, 1; cache_request_stall, input, 1, the cache response.
REQ-013 SHALL have port owner, output, 2, giving the current state encoding.

Function
REQ-014 SHALL implement states IDLE, GNT_FSM and GNT_BUS, held in a registered state.
REQ-015 IDLE SHALL drive all cache_* outputs to 0 and both *_request_stall outputs to 1.
REQ-016 In IDLE, rdata outputs SHALL read 32'hBAD1BAD1 and error outputs SHALL be 0.
REQ-017 In GNT_X, requester X's request signals SHALL pass to cache_* combinationally.
REQ-018 In GNT_X, cache_rdata, cache_error and cache_request_stall SHALL pass to X's outputs.
REQ-019 In GNT_X, the non-owner SHALL see request_stall=1, rdata=32'hBAD1BAD1 and error=0.
REQ-020 A requester SHALL count as pending when its ren|wen is high.
REQ-021 From IDLE, the next state SHALL be GNT_FSM if the FSM is pending, else GNT_BUS if the bus is pending, else IDLE; a grant costs exactly one cycle of latency.
REQ-022 In GNT_X with X still pending, the state SHALL hold, except as stated in REQ-030.
REQ-023 When owner X drops its request, the next state SHALL be GNT_other if the other requester is pending, else IDLE, with no idle gap.
REQ-024 Ownership SHALL change only when the owner is not pending or cache_request_stall=0, so an in-flight access is never torn.
REQ-025 A requester asserting ren and wen together SHALL be forwarded as-is; the cache resolves it, and the arbiter adds no error.
REQ-026 A requester's address, data or strobe changing while it is stalled SHALL have no effect on the state.
REQ-027 owner SHALL read 2'b00 in IDLE, 2'b01 in GNT_FSM and 2'b10 in GNT_BUS.

Reset
REQ-028 While n_rst=0 at a rising edge, the state SHALL become IDLE and the starvation counter 0, so the outputs after that edge match REQ-015 and REQ-016.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction; no grant is restored after reset.

Configuration
REQ-030 With macro CACHE_ARB_STARVE_EN defined, a counter SHALL increment on each GNT_FSM cycle with the bus pending and clear otherwise.
REQ-031 With CACHE_ARB_STARVE_EN defined, when the counter equals STARVE_LIMIT-1 and cache_request_stall=0, the next state SHALL be GNT_BUS and the counter SHALL clear.
REQ-032 With CACHE_ARB_STARVE_EN undefined, no counter SHALL exist, the FSM SHALL hold ownership indefinitely, and REQ-030 and REQ-031 do not apply.

Structure
REQ-033 The arb_state_e typedef (IDLE=0, GNT_FSM=1, GNT_BUS=2) SHALL reside in chiplet_types_pkg.
REQ-034 The BAD_RDATA constant (32'hBAD1BAD1) SHALL reside in chiplet_types_pkg.
REQ-035 The design SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-036 Bench SHALL cover: fsm_ren=1 in IDLE -> GNT_FSM next cycle; cache_addr=fsm_addr; bus_request_stall=1.
REQ-037 Bench SHALL cover: fsm and bus request in the same IDLE cycle -> GNT_FSM; the FSM drops -> GNT_BUS on the next cycle with no IDLE gap.
REQ-038 Bench SHALL cover: owner bus, cache_request_stall=1 for 3 cycles -> owner stays 2'b10 and the FSM stays stalled until the stall clears.
REQ-039 Bench SHALL cover: with STARVE_EN, STARVE_LIMIT=8, FSM continuously pending and bus pending -> GNT_BUS after 8 FSM cycles.
REQ-040 Bench SHALL cover: without STARVE_EN, the same stimulus for 50 cycles -> owner stays 2'b01.
REQ-041 Bench SHALL cover: n_rst=0 during GNT_BUS -> after the edge, owner=2'b00, cache_wen=0 and both stalls=1.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - shared types and constants for the cache port arbiter
//
// Contents:
//   arb_state_e : arbiter state encoding (IDLE=0, GNT_FSM=1, GNT_BUS=2)
//   BAD_RDATA   : read data returned to a requester that does not own the cache

package chiplet_types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_FSM = 2'd1,
    GNT_BUS = 2'd2
  } arb_state_e;

  localparam logic [31:0] BAD_RDATA = 32'hBAD1BAD1;

endpackage

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-requester arbiter in front of a single-port cache
//
// Purpose:
//   Shares one single-port cache between an FSM requester and a bus requester.
//   The FSM wins simultaneous requests from IDLE. A grant takes one cycle.
//   Ownership only moves when the owner has dropped its request or the cache
//   is not stalling, so an in-flight access is never split.
//
// Optional feature (macro CACHE_ARB_STARVE_EN):
//   When defined, a counter tracks consecutive GNT_FSM cycles with the bus
//   waiting. At STARVE_LIMIT-1, with the cache not stalling, ownership is
//   forced to the bus. When undefined, the FSM keeps ownership indefinitely.
//
// Ports:
//   clk, n_rst                     : clock, synchronous active-low reset
//   fsm_ren/wen/addr/wdata/strobe  : FSM request
//   fsm_rdata/error/request_stall  : FSM response
//   bus_ren/wen/addr/wdata/strobe  : bus request
//   bus_rdata/error/request_stall  : bus response
//   cache_ren/wen/addr/wdata/strobe: request to the cache
//   cache_rdata/error/request_stall: response from the cache
//   owner                          : current state encoding

module cache_port_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,

  input  logic                  fsm_ren,
  input  logic                  fsm_wen,
  input  logic [ADDR_WIDTH-1:0] fsm_addr,
  input  logic [31:0]           fsm_wdata,
  input  logic [3:0]            fsm_strobe,
  output logic [31:0]           fsm_rdata,
  output logic                  fsm_error,
  output logic                  fsm_request_stall,

  input  logic                  bus_ren,
  input  logic                  bus_wen,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wdata,
  input  logic [3:0]            bus_strobe,
  output logic [31:0]           bus_rdata,
  output logic                  bus_error,
  output logic                  bus_request_stall,

  output logic                  cache_ren,
  output logic                  cache_wen,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [31:0]           cache_wdata,
  output logic [3:0]            cache_strobe,
  input  logic [31:0]           cache_rdata,
  input  logic                  cache_error,
  input  logic                  cache_request_stall,

  output logic [1:0]            owner
);

  import chiplet_types_pkg::*;

  arb_state_e state_q;
  arb_state_e state_d;

  logic fsm_pend;
  logic bus_pend;
  logic starve_take;

  assign fsm_pend = fsm_ren | fsm_wen;
  assign bus_pend = bus_ren | bus_wen;

`ifdef CACHE_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] starve_cnt_q;

  // Forced hand-off: only on a clean cycle so the FSM access is not split.
  assign starve_take = (state_q == GNT_FSM) && fsm_pend &&
                       (starve_cnt_q == CNT_LAST) && !cache_request_stall;

  // Saturates at the last value so a long cache stall cannot wrap the count
  // and delay the forced hand-off by another full period.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      starve_cnt_q <= '0;
    end else if (starve_take) begin
      starve_cnt_q <= '0;
    end else if ((state_q == GNT_FSM) && bus_pend) begin
      if (starve_cnt_q != CNT_LAST) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end else begin
      starve_cnt_q <= '0;
    end
  end
`else
  assign starve_take = 1'b0;

  // The limit only matters when starvation relief is compiled in.
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fsm_pend) begin
          state_d = GNT_FSM;
        end else if (bus_pend) begin
          state_d = GNT_BUS;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_FSM: begin
        if (!fsm_pend) begin
          state_d = bus_pend ? GNT_BUS : IDLE;
        end else if (starve_take) begin
          state_d = GNT_BUS;
        end
      end
      GNT_BUS: begin
        if (!bus_pend) begin
          state_d = fsm_pend ? GNT_FSM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the owner is wired straight through to the cache; the
  // non-owner sees a stall with poisoned read data.
  always_comb begin
    cache_ren         = 1'b0;
    cache_wen         = 1'b0;
    cache_addr        = '0;
    cache_wdata       = '0;
    cache_strobe      = '0;
    fsm_rdata         = BAD_RDATA;
    fsm_error         = 1'b0;
    fsm_request_stall = 1'b1;
    bus_rdata         = BAD_RDATA;
    bus_error         = 1'b0;
    bus_request_stall = 1'b1;
    case (state_q)
      GNT_FSM: begin
        cache_ren         = fsm_ren;
        cache_wen         = fsm_wen;
        cache_addr        = fsm_addr;
        cache_wdata       = fsm_wdata;
        cache_strobe      = fsm_strobe;
        fsm_rdata         = cache_rdata;
        fsm_error         = cache_error;
        fsm_request_stall = cache_request_stall;
      end
      GNT_BUS: begin
        cache_ren         = bus_ren;
        cache_wen         = bus_wen;
        cache_addr        = bus_addr;
        cache_wdata       = bus_wdata;
        cache_strobe      = bus_strobe;
        bus_rdata         = cache_rdata;
        bus_error         = cache_error;
        bus_request_stall = cache_request_stall;
      end
      default: ;
    endcase
  end

  assign owner = state_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed self-checking bench for cache_port_arbiter

module tb_cache_port_arbiter;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          fsm_ren, fsm_wen;
  logic [AW-1:0] fsm_addr;
  logic [31:0]   fsm_wdata;
  logic [3:0]    fsm_strobe;
  logic [31:0]   fsm_rdata;
  logic          fsm_error, fsm_request_stall;
  logic          bus_ren, bus_wen;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_strobe;
  logic [31:0]   bus_rdata;
  logic          bus_error, bus_request_stall;
  logic          cache_ren, cache_wen;
  logic [AW-1:0] cache_addr;
  logic [31:0]   cache_wdata;
  logic [3:0]    cache_strobe;
  logic [31:0]   cache_rdata;
  logic          cache_error, cache_request_stall;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;

  cache_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .fsm_ren(fsm_ren), .fsm_wen(fsm_wen), .fsm_addr(fsm_addr),
    .fsm_wdata(fsm_wdata), .fsm_strobe(fsm_strobe),
    .fsm_rdata(fsm_rdata), .fsm_error(fsm_error), .fsm_request_stall(fsm_request_stall),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
    .bus_rdata(bus_rdata), .bus_error(bus_error), .bus_request_stall(bus_request_stall),
    .cache_ren(cache_ren), .cache_wen(cache_wen), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_strobe(cache_strobe),
    .cache_rdata(cache_rdata), .cache_error(cache_error),
    .cache_request_stall(cache_request_stall),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0;
    fsm_ren = 0; fsm_wen = 0; fsm_addr = '0; fsm_wdata = '0; fsm_strobe = '0;
    bus_ren = 0; bus_wen = 0; bus_addr = '0; bus_wdata = '0; bus_strobe = '0;
    cache_rdata = 32'h0; cache_error = 0; cache_request_stall = 1;
    tick(); tick();
    n_rst = 1'b1;
    #1;

    // Reset state
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_fsm_stall", 32'(fsm_request_stall), 32'h1);
    check("rst_bus_stall", 32'(bus_request_stall), 32'h1);
    check("rst_fsm_rdata", fsm_rdata, 32'hBAD1BAD1);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    check("rst_cache_ren", 32'(cache_ren), 32'h0);

    // FSM read from IDLE: one cycle of latency, then pass-through
    fsm_ren = 1; fsm_addr = 9'h1A4;
    cache_rdata = 32'h12345678; cache_error = 1; cache_request_stall = 0;
    #1;
    check("fsm_lat_owner", 32'(owner), 32'h0);
    check("fsm_lat_cache_ren", 32'(cache_ren), 32'h0);
    tick();
    check("fsm_gnt_owner", 32'(owner), 32'h1);
    check("fsm_gnt_addr", 32'(cache_addr), 32'h1A4);
    check("fsm_gnt_ren", 32'(cache_ren), 32'h1);
    check("fsm_gnt_bus_stall", 32'(bus_request_stall), 32'h1);
    check("fsm_gnt_bus_rdata", bus_rdata, 32'hBAD1BAD1);
    check("fsm_gnt_rdata", fsm_rdata, 32'h12345678);
    check("fsm_gnt_error", 32'(fsm_error), 32'h1);
    check("fsm_gnt_bus_error", 32'(bus_error), 32'h0);
    check("fsm_gnt_stall", 32'(fsm_request_stall), 32'h0);

    // FSM drops with nobody waiting -> IDLE
    fsm_ren = 0; cache_error = 0;
    tick();
    check("drop_idle_owner", 32'(owner), 32'h0);
    check("drop_idle_ren", 32'(cache_ren), 32'h0);

    // Simultaneous requests: FSM first, then bus with no idle gap
    fsm_wen = 1; fsm_wdata = 32'hCAFEF00D; fsm_strobe = 4'b0101;
    bus_ren = 1; bus_addr = 9'h0F0;
    tick();
    check("both_owner", 32'(owner), 32'h1);
    check("both_cache_wen", 32'(cache_wen), 32'h1);
    check("both_cache_wdata", cache_wdata, 32'hCAFEF00D);
    check("both_cache_strobe", 32'(cache_strobe), 32'h5);
    fsm_wen = 0;
    tick();
    check("handoff_owner", 32'(owner), 32'h2);
    check("handoff_addr", 32'(cache_addr), 32'h0F0);
    check("handoff_fsm_stall", 32'(fsm_request_stall), 32'h1);
    check("handoff_bus_stall", 32'(bus_request_stall), 32'h0);

    // Bus owns, cache stalls 3 cycles; FSM waits and bus fields wiggle.
    // Bus also asserts ren and wen together: forwarded unchanged.
    fsm_ren = 1; bus_wen = 1; cache_request_stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus_addr = 9'(9'h100 + i); bus_wdata = 32'(i);
      tick();
      check("stall_owner", 32'(owner), 32'h2);
      check("stall_fsm_stall", 32'(fsm_request_stall), 32'h1);
      check("stall_bus_stall", 32'(bus_request_stall), 32'h1);
      check("stall_ren_wen", {30'h0, cache_ren, cache_wen}, 32'h3);
      check("stall_bus_error", 32'(bus_error), 32'h0);
    end
    cache_request_stall = 0; bus_ren = 0; bus_wen = 0;
    #1;
    check("unstall_fsm_stall", 32'(fsm_request_stall), 32'h1);
    tick();
    check("unstall_owner", 32'(owner), 32'h1);
    check("unstall_fsm_stall2", 32'(fsm_request_stall), 32'h0);

    // Starvation: reset to a clean IDLE, then both continuously pending
    fsm_ren = 0;
    n_rst = 0;
    tick();
    n_rst = 1;
    fsm_ren = 1; bus_ren = 1;
    tick();
    check("starve_enter_owner", 32'(owner), 32'h1);
`ifdef CACHE_ARB_STARVE_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      check("starve_hold_owner", 32'(owner), 32'h1);
    end
    tick();
    check("starve_force_owner", 32'(owner), 32'h2);
`else
    for (int i = 0; i < 50; i++) begin
      tick();
      check("nostarve_owner", 32'(owner), 32'h1);
    end
`endif

    // Reach GNT_BUS with a write in flight, then reset mid-transaction
    fsm_ren = 0; bus_ren = 0; bus_wen = 1;
    tick();
    check("pre_rst_owner", 32'(owner), 32'h2);
    check("pre_rst_wen", 32'(cache_wen), 32'h1);
    n_rst = 0;
    tick();
    check("midrst_owner", 32'(owner), 32'h0);
    check("midrst_wen", 32'(cache_wen), 32'h0);
    check("midrst_fsm_stall", 32'(fsm_request_stall), 32'h1);
    check("midrst_bus_stall", 32'(bus_request_stall), 32'h1);
    check("midrst_bus_rdata", bus_rdata, 32'hBAD1BAD1);
    n_rst = 1; bus_wen = 0;
    tick();
    check("post_rst_owner", 32'(owner), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
